// File: rtl/gpio_key_debounce_if.sv
// Key/GPIO debounce bus: raw pad levels and interrupt controls in, debounced
// levels, edge pulses and interrupt status out.
interface gpio_key_debounce_if #(
  parameter int unsigned DATA_WIDTH = 3
);

  logic [DATA_WIDTH-1:0] key_in;
  logic [DATA_WIDTH-1:0] irq_en;
  logic [DATA_WIDTH-1:0] irq_clear;
  logic [DATA_WIDTH-1:0] key_level;
  logic [DATA_WIDTH-1:0] key_press;
  logic [DATA_WIDTH-1:0] key_release;
  logic [DATA_WIDTH-1:0] irq_pending;
  logic                  irq;

  // Driver side: pads and register-file controls.
  modport master (
    output key_in,
    output irq_en,
    output irq_clear,
    input  key_level,
    input  key_press,
    input  key_release,
    input  irq_pending,
    input  irq
  );

  // Debouncer side.
  modport slave (
    input  key_in,
    input  irq_en,
    input  irq_clear,
    output key_level,
    output key_press,
    output key_release,
    output irq_pending,
    output irq
  );

endinterface

// File: rtl/gpio_key_debounce.sv
// Per-bit key debouncer: 2-flop synchronizer, stability counter, registered
// press/release pulses and sticky press-interrupt flags with a registered irq.
module gpio_key_debounce #(
  parameter int unsigned DATA_WIDTH      = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  gpio_key_debounce_if.slave bus
);

  localparam int unsigned           CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DATA_WIDTH-1:0] IDLE_LEVEL = {DATA_WIDTH{ACTIVE_LOW}};
  localparam logic                  PRESSED    = ~ACTIVE_LOW;

  logic [DATA_WIDTH-1:0] sync_meta;
  logic [DATA_WIDTH-1:0] sync;
  logic [DATA_WIDTH-1:0] level_q;
  logic [DATA_WIDTH-1:0] press_q;
  logic [DATA_WIDTH-1:0] release_q;
  logic [DATA_WIDTH-1:0] pending_q;
  logic                  irq_q;
  logic [CNT_W-1:0]      cnt_q [DATA_WIDTH];

  // Two-stage synchronizer; reset to the inactive level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= IDLE_LEVEL;
      sync      <= IDLE_LEVEL;
    end else begin
      sync_meta <= bus.key_in;
      sync      <= sync_meta;
    end
  end

  // Per-bit stability counter; a mismatch must persist DEBOUNCE_CYCLES samples to be accepted.
  for (genvar i = 0; i < int'(DATA_WIDTH); i++) begin : g_bit
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[i]     <= '0;
        level_q[i]   <= ACTIVE_LOW;
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
      end else begin
        press_q[i]   <= 1'b0;
        release_q[i] <= 1'b0;
        if (sync[i] == level_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i]     <= '0;
          level_q[i]   <= sync[i];
          press_q[i]   <= (sync[i] == PRESSED);
          release_q[i] <= (sync[i] != PRESSED);
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky press flags: new enabled events win over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~bus.irq_clear) | (press_q & bus.irq_en);
      irq_q     <= |pending_q;
    end
  end

  assign bus.key_level   = level_q;
  assign bus.key_press   = press_q;
  assign bus.key_release = release_q;
  assign bus.irq_pending = pending_q;
  assign bus.irq         = irq_q;

endmodule

// File: tb/tb_gpio_key_debounce.sv
// Directed bench for gpio_key_debounce (3 bits, 4-cycle debounce, active-low keys).
module tb_gpio_key_debounce;

  localparam int unsigned DW = 3;

  typedef struct {
    logic          rst;
    logic [DW-1:0] key_in;
    logic [DW-1:0] irq_en;
    logic [DW-1:0] irq_clear;
    logic [DW-1:0] exp_level;
    logic [DW-1:0] exp_press;
    logic [DW-1:0] exp_release;
    logic [DW-1:0] exp_pending;
    logic          exp_irq;
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  vec_t tbl [$];

  gpio_key_debounce_if #(.DATA_WIDTH(DW)) bus ();

  gpio_key_debounce #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b1)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ticks until the selected pulse vector equals mask (bounded) and checks latency.
  task automatic wait_evt(input string name, input bit rel, input logic [DW-1:0] mask,
                          input int exp_n);
    int            n;
    logic [DW-1:0] s;
    n = 0;
    do begin
      tick();
      n++;
      s = rel ? bus.key_release : bus.key_press;
    end while (s != mask && n < 20);
    chk({name, " pulse"}, 32'(s), 32'(mask));
    chk({name, " latency"}, 32'(n), 32'(exp_n));
  endtask

  function automatic vec_t mk(logic r, logic [DW-1:0] k, logic [DW-1:0] en, logic [DW-1:0] clr,
                              logic [DW-1:0] lvl, logic [DW-1:0] prs, logic [DW-1:0] rel,
                              logic [DW-1:0] pnd, logic q);
    vec_t v;
    v.rst = r; v.key_in = k; v.irq_en = en; v.irq_clear = clr;
    v.exp_level = lvl; v.exp_press = prs; v.exp_release = rel;
    v.exp_pending = pnd; v.exp_irq = q;
    return v;
  endfunction

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.key_in = 3'b111;
    bus.irq_en = 3'b111;
    bus.irq_clear = 3'b000;

    // Reset: everything inactive.
    for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 3'b111, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 0));
    // Glitch: bit1 low for 3 samples, one short of acceptance.
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 3'b101, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 0));
    for (int i = 0; i < 6; i++) tbl.push_back(mk(0, 3'b111, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 0));
    // Clean press on bit0: level on edge 6, pending edge 7, irq edge 8, then clear.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3'b110, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b110, 3'b111, 3'b000, 3'b110, 3'b001, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b110, 3'b111, 3'b000, 3'b110, 3'b000, 3'b000, 3'b001, 0));
    tbl.push_back(mk(0, 3'b110, 3'b111, 3'b000, 3'b110, 3'b000, 3'b000, 3'b001, 1));
    tbl.push_back(mk(0, 3'b110, 3'b111, 3'b001, 3'b110, 3'b000, 3'b000, 3'b000, 1));
    tbl.push_back(mk(0, 3'b110, 3'b111, 3'b000, 3'b110, 3'b000, 3'b000, 3'b000, 0));
    // Masked press on bit2: pulse but no pending/irq.
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b110, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000, 3'b000, 0));
    for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b000, 0));

    foreach (tbl[i]) begin
      rst           = tbl[i].rst;
      bus.key_in    = tbl[i].key_in;
      bus.irq_en    = tbl[i].irq_en;
      bus.irq_clear = tbl[i].irq_clear;
      tick();
      chk($sformatf("vec%0d key_level", i),   32'(bus.key_level),   32'(tbl[i].exp_level));
      chk($sformatf("vec%0d key_press", i),   32'(bus.key_press),   32'(tbl[i].exp_press));
      chk($sformatf("vec%0d key_release", i), 32'(bus.key_release), 32'(tbl[i].exp_release));
      chk($sformatf("vec%0d irq_pending", i), 32'(bus.irq_pending), 32'(tbl[i].exp_pending));
      chk($sformatf("vec%0d irq", i),         32'(bus.irq),         32'(tbl[i].exp_irq));
    end

    // Clear/set collision on bit0.
    bus.irq_en = 3'b111;
    bus.key_in = 3'b011;
    wait_evt("rel0a", 1'b1, 3'b001, 6);
    chk("rel0a level", 32'(bus.key_level), 32'(3'b011));
    bus.key_in = 3'b010;
    wait_evt("press0a", 1'b0, 3'b001, 6);
    tick();
    chk("press0a pending", 32'(bus.irq_pending), 32'(3'b001));
    tick();
    chk("press0a irq", 32'(bus.irq), 32'(1));
    bus.key_in = 3'b011;
    wait_evt("rel0b", 1'b1, 3'b001, 6);
    bus.key_in = 3'b010;
    wait_evt("press0b", 1'b0, 3'b001, 6);
    bus.irq_clear = 3'b001;
    tick();
    chk("collision set wins", 32'(bus.irq_pending), 32'(3'b001));
    tick();
    chk("clear alone", 32'(bus.irq_pending), 32'(3'b000));
    chk("irq lags clear", 32'(bus.irq), 32'(1));
    bus.irq_clear = 3'b000;
    tick();
    chk("irq drops", 32'(bus.irq), 32'(0));

    // Reset mid-count: partial count discarded, full latency after release of reset.
    bus.key_in = 3'b111;
    wait_evt("rel02", 1'b1, 3'b101, 6);
    bus.key_in = 3'b110;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst level", 32'(bus.key_level), 32'(3'b111));
    chk("midrst press", 32'(bus.key_press), 32'(3'b000));
    chk("midrst release", 32'(bus.key_release), 32'(3'b000));
    chk("midrst irq", 32'(bus.irq), 32'(0));
    rst = 1'b0;
    wait_evt("press after rst", 1'b0, 3'b001, 6);

    // Multi-bit: press the rest, then release all together.
    bus.key_in = 3'b000;
    wait_evt("press12", 1'b0, 3'b110, 6);
    chk("all pressed level", 32'(bus.key_level), 32'(3'b000));
    bus.key_in = 3'b111;
    wait_evt("rel all", 1'b1, 3'b111, 6);
    chk("rel all level", 32'(bus.key_level), 32'(3'b111));
    tick();
    chk("rel all one cycle", 32'(bus.key_release), 32'(3'b000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_key_debounce.md
GPIO_KEY_DEBOUNCE -- requirements
Module: gpio_key_debounce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 3, number of key/GPIO input bits.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, consecutive stable samples required to accept a new level (legal range >= 1).
REQ-003 SHALL have parameter ACTIVE_LOW, default 1; when 1, logic 0 at the pad means "pressed".
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port key_in, input, DATA_WIDTH bits: raw asynchronous pad level from the GPIO IOBUF input path.
REQ-007 SHALL have port irq_en, input, DATA_WIDTH bits: per-bit interrupt enable.
REQ-008 SHALL have port irq_clear, input, DATA_WIDTH bits: per-bit write-1-to-clear strobe for pending bits.
REQ-009 SHALL have port key_level, output, DATA_WIDTH bits: debounced pad level, raw polarity.
REQ-010 SHALL have port key_press, output, DATA_WIDTH bits: one-cycle pulse on a debounced inactive->active transition.
REQ-011 SHALL have port key_release, output, DATA_WIDTH bits: one-cycle pulse on a debounced active->inactive transition.
REQ-012 SHALL have port irq_pending, output, DATA_WIDTH bits: sticky per-bit press-event flags.
REQ-013 SHALL have port irq, output, 1 bit: registered OR of irq_pending.

Function
REQ-014 SHALL pass each key_in bit through a 2-flop synchronizer; the second-stage output (sync) is the only internal use of key_in.
REQ-015 SHALL keep, per bit, a counter of width clog2(DEBOUNCE_CYCLES+1) and the accepted level key_level.
REQ-016 SHALL, per bit, each cycle:
- sync == key_level: clear the counter to 0.
- sync != key_level and counter < DEBOUNCE_CYCLES-1: increment the counter.
- sync != key_level and counter == DEBOUNCE_CYCLES-1: load key_level <= sync and clear the counter.
REQ-017 SHALL restart the count from 0 whenever a glitch returns sync to key_level before acceptance; key_level SHALL NOT change in that case.
REQ-018 SHALL update key_level exactly DEBOUNCE_CYCLES+2 rising edges after key_in settles at a new level, counting from the first edge that samples the new level.
REQ-019 SHALL register key_press and key_release so that each asserts in the same cycle key_level changes, for exactly one cycle; "active" means key_level == !ACTIVE_LOW.
REQ-020 SHALL set irq_pending[i] on the cycle after key_press[i] is 1, if irq_en[i] was 1 in the same cycle as the key_press[i] pulse.
REQ-021 SHALL clear irq_pending[i] on the cycle after irq_clear[i] == 1; if set and clear coincide, set SHALL win and the bit SHALL remain 1.
REQ-022 SHALL drive irq as a register equal to |irq_pending from the previous cycle, so irq lags irq_pending by one cycle.
REQ-023 SHALL never clear an already-pending bit when irq_en[i] is deasserted; irq_en gates only new events.
REQ-024 SHALL process the bits independently; simultaneous transitions on several bits SHALL each produce their own pulses in the same cycle.
REQ-025 SHALL NOT wrap the counter; it saturates by construction at DEBOUNCE_CYCLES-1 before acceptance.

Reset
REQ-026 SHALL, while rst == 1 at a clock edge, load the following:
- synchronizer flops and key_level = {DATA_WIDTH{ACTIVE_LOW}}, i.e. inactive.
- counters = 0.
- key_press, key_release, irq_pending and irq = 0.
REQ-027 SHALL, on reset asserted mid-count, discard the partial count; after rst deasserts, a held key SHALL require the full DEBOUNCE_CYCLES+2 again and then emit key_press.
REQ-028 SHALL NOT generate key_press or key_release as a consequence of reset itself.

Verification (DATA_WIDTH=3, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1)
REQ-029 Clean press: key_in[0] 1->0 held -> key_level[0]=0 on edge 6 after change; key_press=001 for one cycle; irq_pending=001 next cycle (irq_en=111); irq=1 one cycle later.
REQ-030 Glitch: key_in[1] low for 3 cycles, then high -> key_level unchanged at 111, no pulses, irq stays 0.
REQ-031 Clear/set collision: irq_pending[0]=1, then irq_clear=001 in the cycle key_press[0] pulses again -> irq_pending[0] stays 1; irq_clear=001 alone -> 0 next cycle; irq -> 0 one cycle later.
REQ-032 Masked event: irq_en=000, press key_in[2] -> key_press=100 pulse, irq_pending stays 000, irq stays 0.
REQ-033 Reset mid-count: key_in=110 held, rst=1 for 1 cycle at count 2 -> no pulse during reset; key_press=001 exactly 6 edges after rst deasserts.
REQ-034 Multi-bit release: all keys pressed and stable, then key_in 000->111 together -> key_release=111 in a single cycle, key_level=111.
